conv_enc_213: RTL and testbench
===============================

CONV_ENC_213 -- requirements
Module: conv_enc_213

Interface
REQ-001 Parameter G0, default 3'b111, generator for sym[1]; bit 2 taps the current bit, bit 1 taps d(n-1), bit 0 taps d(n-2).
REQ-002 Parameter G1, default 3'b101, generator for sym[0]; tap order is the same as G0.
REQ-003 clock  input  1  all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  frame start request, sampled only in IDLE.
REQ-006 frame_len  input  4  information bits per frame, sampled with start; legal range is 1..13.
REQ-007 din  input  1  information bit.
REQ-008 din_valid  input  1  din is valid.
REQ-009 din_ready  output  1  encoder accepts din this cycle.
REQ-010 sym  output  2  coded symbol {c1,c0}.
REQ-011 sym_valid  output  1  sym holds a valid symbol.
REQ-012 sym_ready  input  1  downstream accepts sym.
REQ-013 stage  output  4  frame index of the symbol on sym, 0-based.
REQ-014 we  output  1  symbol-transfer strobe; same meaning as the decoder write enable.
REQ-015 busy  output  1  frame in progress (state other than IDLE).
REQ-016 done  output  1  one-cycle pulse when the frame completes.

Function
REQ-017 The FSM states SHALL be IDLE, DATA, TAIL and DRAIN.
REQ-018 IDLE->DATA on start=1 with frame_len!=0: clear shift register sr[1:0] (sr[1]=d(n-1), sr[0]=d(n-2)), bit counter and stage; load len = min(frame_len,13).
REQ-019 start with frame_len=0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-020 Output slot free = !sym_valid || sym_ready (single-entry output register, ready passed through).
REQ-021 din_ready = (state==DATA) && slot free; a bit transfers when din_valid && din_ready.
REQ-022 On bit transfer with input u: sym <= {^(G0&{u,sr}), ^(G1&{u,sr})}; sym_valid <= 1; sr <= {u,sr[1]}; bit counter increments.
REQ-023 Latency: sym_valid is high the cycle after the bit transfer; sustained throughput is 1 symbol per cycle when sym_ready=1.
REQ-024 DATA->TAIL on the transfer of bit number len.
REQ-025 In TAIL, each cycle with the slot free the block SHALL encode an internal u=0 exactly as in REQ-022; after 2 tail symbols are loaded it SHALL go to DRAIN.
REQ-026 DRAIN->IDLE when the last symbol transfers; done SHALL pulse that same cycle; sr SHALL return to 2'b00.
REQ-027 sym_valid SHALL clear on transfer (sym_valid && sym_ready) if no new symbol loads that cycle; sym SHALL hold while sym_valid && !sym_ready.
REQ-028 we = sym_valid && sym_ready (combinational).
REQ-029 stage SHALL increment by 1 on each transfer; the frame total is len+2 <= 15, so stage never wraps within a frame.
REQ-030 stage SHALL be cleared on the IDLE->DATA transition.
REQ-031 frame_len > 13 SHALL be clamped to 13.
REQ-032 din_valid outside DATA SHALL be ignored with din_ready=0.

Reset
REQ-033 reset=1 SHALL force, at any time including mid-frame: state=IDLE, sr=0, counters=0, sym=2'b00, sym_valid=0, stage=0, busy=0, done=0; din_ready=0 and we=0 follow from this.
REQ-034 After reset deassertion the first legal start SHALL begin a clean frame.

Verification
REQ-035 frame_len=4, din 1,0,1,1 back-to-back, sym_ready=1 -> sym sequence 11,10,00,01,01,11; stage 0..5; we high 6 cycles; done pulses with the 6th transfer.
REQ-036 Same frame with sym_ready=0 for 3 cycles after the 1st symbol -> sym holds 11 and stage holds 0; din_ready=0 while stalled; no symbol lost or duplicated.
REQ-037 start with frame_len=0 -> busy stays 0; start during a frame -> no effect on the sequence.
REQ-038 reset asserted after the 2nd symbol -> next cycle all outputs are at reset values; a new frame of 1 bit 1 -> 11,10,11.
REQ-039 frame_len=15 -> exactly 13 data bits accepted, 15 symbols, final stage=14.
REQ-040 Random din/din_valid/sym_ready, 200 frames -> output matches a reference encoder model; done count equals frame count.

Source files
------------

// File: rtl/conv_enc_213.sv
// Rate-1/2, constraint-length-3 convolutional encoder with framed input,
// two zero tail bits and a single-entry ready/valid output register.
module conv_enc_213 #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] frame_len,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [3:0] stage,
  output logic       we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [1:0] sr;
  logic [3:0] cnt;
  logic [3:0] len;
  logic       tcnt;
  logic       slot_free;
  logic       bit_xfer;
  logic       tail_load;
  logic       load;
  logic       u;
  logic       frame_go;

  function automatic logic encode(input logic [2:0] g, input logic ui,
                                  input logic [1:0] s);
    return ^(g & {ui, s});
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    return (l > 4'd13) ? 4'd13 : l;
  endfunction

  assign slot_free = !sym_valid || sym_ready;
  assign we        = sym_valid && sym_ready;
  assign din_ready = (state == DATA) && slot_free;
  assign busy      = (state != IDLE);
  // Only the final symbol can be in the register while draining.
  assign done      = (state == DRAIN) && we;
  assign bit_xfer  = din_valid && din_ready;
  assign tail_load = (state == TAIL) && slot_free;
  assign load      = bit_xfer || tail_load;
  assign u         = bit_xfer && din;
  assign frame_go  = (state == IDLE) && start && (frame_len != 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_go) state_nxt = DATA;
      DATA:    if (bit_xfer && (cnt + 4'd1 == len)) state_nxt = TAIL;
      TAIL:    if (tail_load && tcnt) state_nxt = DRAIN;
      DRAIN:   if (we) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output register stage: symbol, its valid and its frame index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= 2'b00;
      cnt       <= 4'd0;
      len       <= 4'd0;
      tcnt      <= 1'b0;
      sym       <= 2'b00;
      sym_valid <= 1'b0;
      stage     <= 4'd0;
    end else begin
      state <= state_nxt;
      if (frame_go) begin
        sr    <= 2'b00;
        cnt   <= 4'd0;
        tcnt  <= 1'b0;
        stage <= 4'd0;
        len   <= clamp_len(frame_len);
      end else begin
        if (load) begin
          sr  <= {u, sr[1]};
          sym <= {encode(G0, u, sr), encode(G1, u, sr)};
        end
        if (bit_xfer)  cnt   <= cnt + 4'd1;
        if (tail_load) tcnt  <= 1'b1;
        if (we)        stage <= stage + 4'd1;
        if (done)      sr    <= 2'b00;
      end
      if (load)    sym_valid <= 1'b1;
      else if (we) sym_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_enc_213.sv
// Bench for conv_enc_213: directed frames plus 200 random frames, all symbols
// checked against a frame-level encoder model on every output transfer.
module tb_conv_enc_213;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] frame_len;
  logic       din, din_valid, din_ready;
  logic [1:0] sym;
  logic       sym_valid, sym_ready;
  logic [3:0] stage;
  logic       we, busy, done;

  conv_enc_213 #(.G0(G0), .G1(G1)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sym(sym), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .stage(stage), .we(we), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct { logic [1:0] s; logic [3:0] st; logic last; } exp_t;
  exp_t       eq[$];
  logic [1:0] got[$];

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  logic s_din_ready, s_xfer, s_we, s_done;
  logic prev_stall = 1'b0, prev_xfer = 1'b0;
  logic [1:0] prev_sym;
  logic [3:0] prev_stage, last_stage;
  int f_cyc, f_idx, f_nsym;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic bitat(input int l, input logic [12:0] b, input int i);
    if (i < 0 || i >= l) return 1'b0;
    return b[i[3:0]];
  endfunction

  // Symbol i of a frame: data bits followed by two zeros, fed through the generators.
  function automatic logic [1:0] model_sym(input int l, input logic [12:0] b, input int i);
    logic [2:0] w;
    w = {bitat(l, b, i), bitat(l, b, i - 1), bitat(l, b, i - 2)};
    return {^(G0 & w), ^(G1 & w)};
  endfunction

  task automatic push_frame(input int l, input logic [12:0] b);
    exp_t e;
    for (int i = 0; i < l + 2; i++) begin
      e.s = model_sym(l, b, i);
      e.st = 4'(i);
      e.last = (i == l + 1);
      eq.push_back(e);
    end
  endtask

  task automatic mon();
    exp_t e;
    s_din_ready = 1'b0; s_xfer = 1'b0; s_we = 1'b0; s_done = 1'b0;
    if (reset) begin
      prev_stall = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      s_din_ready = din_ready;
      s_xfer = din_valid && din_ready;
      s_we = we;
      s_done = done;
      if (prev_stall) begin
        chk("hold_sym", int'(sym), int'(prev_sym));
        chk("hold_stage", int'(stage), int'(prev_stage));
        chk("hold_valid", int'(sym_valid), 1);
      end
      if (prev_xfer) chk("latency_valid", int'(sym_valid), 1);
      chk("we_strobe", int'(we), int'(sym_valid && sym_ready));
      if (!busy) chk("idle_din_ready", int'(din_ready), 0);
      if (we) begin
        if (eq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_sym: got %b expected no symbol", sym);
        end else begin
          e = eq.pop_front();
          chk("sym", int'(sym), int'(e.s));
          chk("stage", int'(stage), int'(e.st));
          chk("done_on_last", int'(done), int'(e.last));
          got.push_back(sym);
          last_stage = stage;
        end
      end else begin
        chk("done_no_xfer", int'(done), 0);
      end
      if (done) done_cnt++;
      prev_stall = sym_valid && !sym_ready;
      prev_xfer  = s_xfer;
      prev_sym   = sym;
      prev_stage = stage;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    mon();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; din_valid = 1'b0; din = 1'b0; sym_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    eq.delete();
  endtask

  task automatic run_frame(input int flen, input logic [12:0] bits, input bit rand_v,
                           input bit rand_r, input bit stall_first, input bit start_mid,
                           input int abort_after);
    int l, stall_ctr;
    bit fin, stalled;
    l = (flen > 13) ? 13 : flen;
    f_cyc = 0; f_idx = 0; f_nsym = 0; stall_ctr = 0; fin = 0;
    got.delete();
    push_frame(l, bits);
    start = 1'b1; frame_len = 4'(flen); din_valid = 1'b0; sym_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && f_cyc < 200) begin
      din_valid = (f_idx < l) && (rand_v ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (din_valid) din = bits[f_idx[3:0]];
      else           din = 1'($urandom);
      sym_ready = rand_r ? ($urandom_range(0, 3) != 0) : 1'b1;
      stalled = 0;
      if (stall_first && sym_valid && stall_ctr < 3) begin
        sym_ready = 1'b0;
        stall_ctr++;
        stalled = 1;
      end
      start = start_mid && (f_cyc == 2);
      if (start) frame_len = 4'd5;
      tick();
      start = 1'b0;
      f_cyc++;
      if (stalled) chk("stall_din_ready", int'(s_din_ready), 0);
      if (s_xfer) f_idx++;
      if (s_we) f_nsym++;
      if (s_we && s_done) fin = 1;
      if (abort_after != 0 && f_nsym == abort_after) break;
    end
    din_valid = 1'b0;
    if (abort_after == 0) begin
      if (!fin) begin
        checks++;
        $display("FAIL frame_timeout: got no done after %0d cycles expected done", f_cyc);
        do_reset();
      end else begin
        chk("bits_accepted", f_idx, l);
        chk("symbol_count", f_nsym, l + 2);
        chk("queue_empty", eq.size(), 0);
      end
    end
  endtask

  logic [1:0] lit_1011 [6];
  logic [1:0] lit_1    [3];
  int d0;

  initial begin
    lit_1011 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    lit_1    = '{2'b11, 2'b10, 2'b11};
    reset = 1'b1; start = 1'b0; frame_len = 4'd0; din = 1'b0; din_valid = 1'b0;
    sym_ready = 1'b1;
    #1;
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_din_ready", int'(din_ready), 0);
    do_reset();

    // Model pinned by hand-computed symbols for bits 1,0,1,1.
    for (int k = 0; k < 6; k++) chk("model_pin", int'(model_sym(4, 13'b1101, k)), int'(lit_1011[k]));

    // Back-to-back frame at full throughput.
    run_frame(4, 13'b1101, 0, 0, 0, 0, 0);
    chk("throughput_cycles", f_cyc, 7);
    chk("literal_len", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++) chk("literal_1011", int'(got[k]), int'(lit_1011[k]));

    // Same frame with the first symbol stalled three cycles.
    run_frame(4, 13'b1101, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6 && k < got.size(); k++) chk("stalled_1011", int'(got[k]), int'(lit_1011[k]));

    // start with frame_len=0 is ignored.
    start = 1'b1; frame_len = 4'd0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("len0_busy", int'(busy), 0);
      tick();
    end

    // start during a frame has no effect.
    run_frame(6, 13'b101101, 0, 1, 0, 1, 0);
    tick();
    chk("after_mid_start_busy", int'(busy), 0);

    // Reset after the second symbol, then a 1-bit frame.
    run_frame(4, 13'b1101, 0, 0, 0, 0, 2);
    reset = 1'b1;
    #1;
    chk("midrst_sym", int'(sym), 0);
    chk("midrst_sym_valid", int'(sym_valid), 0);
    chk("midrst_stage", int'(stage), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_din_ready", int'(din_ready), 0);
    chk("midrst_we", int'(we), 0);
    tick();
    reset = 1'b0;
    eq.delete();
    run_frame(1, 13'b1, 0, 0, 0, 0, 0);
    chk("one_bit_len", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk("literal_1", int'(got[k]), int'(lit_1[k]));

    // Oversized frame length clamps to 13 data bits.
    run_frame(15, 13'($urandom), 1, 1, 0, 0, 0);
    chk("clamp_bits", f_idx, 13);
    chk("clamp_syms", f_nsym, 15);
    chk("clamp_last_stage", int'(last_stage), 14);

    // Random frames.
    d0 = done_cnt;
    for (int f = 0; f < 200; f++) begin
      run_frame($urandom_range(1, 15), 13'($urandom), 1, 1, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    chk("done_count", done_cnt - d0, 200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
